array_memory: RTL and testbench

Single-port synchronous RAM that backs the `Array` channel type. It sits on the memory side of an `Array` bus and services one read or write request per clock from a single client. Example clients are generated dataflow blocks such as `tests_three_writes`, which issues sequential writes. Storage is 2^ADDR_N words of INT_N bits.

---
 rtl/array_memory_pkg.sv | 24 ++
 rtl/array_memory_ram_sp.sv | 26 ++
 rtl/array_memory.sv | 40 ++++
 tb/tb_array_memory.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/array_memory_pkg.sv
// array_memory_pkg: shared defaults, Array bundle types and handshake helper
package array_memory_pkg;

    localparam int ADDR_N_DEF = 8;
    localparam int INT_N_DEF  = 8;

    typedef struct packed {
        logic [ADDR_N_DEF-1:0] addr;
        logic                  we;
        logic [INT_N_DEF-1:0]  di;
        logic                  valid;
    } array_req_t;

    typedef struct packed {
        logic [INT_N_DEF-1:0] rdata;
        logic                 ready;
    } array_rsp_t;

    // A request takes effect only when offered, accepted, and not held in reset
    function automatic logic accepted(input logic valid, input logic ready, input logic nrst);
        return valid & ready & nrst;
    endfunction

endpackage

// File: rtl/array_memory_ram_sp.sv
// array_memory_ram_sp: generic single-port RAM with registered, clearable read data
module array_memory_ram_sp #(
    parameter int ADDR_N = 8,
    parameter int INT_N  = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_N-1:0] addr,
    input  logic [INT_N-1:0]  wdata,
    output logic [INT_N-1:0]  rdata
);

    logic [INT_N-1:0] mem [2**ADDR_N];

    // Write port; storage is never cleared so contents survive reset
    always_ff @(posedge clk)
        if (en && we) mem[addr] <= wdata;

    // Registered read holds until the next accepted read, clears on reset
    always_ff @(posedge clk)
        if (clr) rdata <= '0;
        else if (en && !we) rdata <= mem[addr];

endmodule

// File: rtl/array_memory.sv
// array_memory: Array-channel RAM with ready/reset control and handshake gating
module array_memory
    import array_memory_pkg::*;
#(
    parameter int ADDR_N = ADDR_N_DEF,
    parameter int INT_N  = INT_N_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ADDR_N-1:0] addr,
    input  logic              we,
    input  logic [INT_N-1:0]  di,
    input  logic              valid,
    output logic              ready,
    output logic [INT_N-1:0]  rdata
);

    logic en;

    assign en = accepted(valid, ready, nrst);

    // Ready follows reset history only: low in reset, high from the first edge out of it
    always_ff @(posedge clk)
        if (!nrst) ready <= 1'b0;
        else ready <= 1'b1;

    array_memory_ram_sp #(
        .ADDR_N(ADDR_N),
        .INT_N (INT_N)
    ) u_ram (
        .clk  (clk),
        .clr  (!nrst),
        .en   (en),
        .we   (we),
        .addr (addr),
        .wdata(di),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_array_memory.sv
// tb_array_memory: directed test of array_memory against a behavioural model
module tb_array_memory;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] addr = '0;
    logic       we = 1'b0;
    logic [7:0] di = '0;
    logic       valid = 1'b0;
    logic       ready;
    logic [7:0] rdata;

    int checks = 0;
    int failures = 0;
    logic chk_on = 1'b0;

    logic [7:0] mem_m [256];
    logic [7:0] do_m = '0;
    logic       ready_m = 1'b0;

    array_memory dut (
        .clk  (clk),
        .nrst (nrst),
        .addr (addr),
        .we   (we),
        .di   (di),
        .valid(valid),
        .ready(ready),
        .rdata(rdata)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 256; i++) mem_m[i] = '0;

    // Model: memory array plus read register and ready flag, updated per clock
    always @(posedge clk) begin
        if (!nrst) begin
            ready_m = 1'b0;
            do_m = '0;
        end else begin
            if (valid && ready_m) begin
                if (we) mem_m[addr] = di;
                else do_m = mem_m[addr];
            end
            ready_m = 1'b1;
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (ready !== ready_m || rdata !== do_m) begin
                failures++;
                $display("FAIL model_cmp t=%0t ready=%0b want %0b rdata=%0d want %0d",
                         $time, ready, ready_m, rdata, do_m);
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic w, input logic [7:0] a, input logic [7:0] d);
        nrst = r;
        valid = v;
        we = w;
        addr = a;
        di = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        chk_on = 1'b1;
        expect_lit("reset_ready", {7'd0, ready}, 8'd0);
        expect_lit("reset_do", rdata, 8'd0);
        drive(1, 0, 0, 0, 0);
        expect_lit("ready_rise", {7'd0, ready}, 8'd1);
        drive(1, 1, 1, 0, 0);
        drive(1, 1, 1, 4, 0);
        drive(1, 1, 1, 5, 0);
        drive(1, 1, 1, 6, 77);
        drive(1, 1, 0, 6, 0);
        expect_lit("pre_reset_read", rdata, 8'd77);
        drive(0, 1, 1, 5, 99);
        drive(0, 1, 1, 5, 99);
        expect_lit("reset_hold_ready", {7'd0, ready}, 8'd0);
        expect_lit("reset_hold_do", rdata, 8'd0);
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 1, 6, 1);
        drive(1, 1, 0, 6, 0);
        expect_lit("read6", rdata, 8'd1);
        drive(1, 1, 0, 5, 0);
        expect_lit("reset_write_dropped", rdata, 8'd0);
        drive(1, 1, 1, 1, 10);
        drive(1, 1, 1, 2, 20);
        drive(1, 1, 1, 3, 30);
        drive(1, 1, 0, 1, 0);
        expect_lit("read1", rdata, 8'd10);
        drive(1, 1, 0, 2, 0);
        expect_lit("read2", rdata, 8'd20);
        drive(1, 1, 0, 3, 0);
        expect_lit("read3", rdata, 8'd30);
        drive(1, 1, 1, 7, 42);
        drive(1, 1, 0, 7, 0);
        expect_lit("raw7", rdata, 8'd42);
        drive(1, 0, 1, 4, 55);
        expect_lit("idle_hold", rdata, 8'd42);
        drive(1, 0, 0, 4, 0);
        drive(1, 1, 0, 4, 0);
        expect_lit("idle_no_write", rdata, 8'd0);
        drive(1, 1, 1, 255, 200);
        drive(1, 1, 0, 255, 0);
        expect_lit("top_addr", rdata, 8'd200);
        drive(1, 1, 0, 0, 0);
        expect_lit("no_alias", rdata, 8'd0);
        drive(1, 1, 1, 9, 11);
        drive(1, 1, 0, 9, 0);
        expect_lit("pre_mid_reset", rdata, 8'd11);
        drive(0, 0, 0, 0, 0);
        expect_lit("mid_reset_do", rdata, 8'd0);
        expect_lit("mid_reset_ready", {7'd0, ready}, 8'd0);
        drive(1, 1, 0, 9, 0);
        expect_lit("deassert_read_dropped", rdata, 8'd0);
        expect_lit("ready_back", {7'd0, ready}, 8'd1);
        drive(1, 1, 0, 9, 0);
        expect_lit("persist9", rdata, 8'd11);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        chk_on = 1'b0;
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
